stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl_pkg.sv | 14 +
 rtl/stopwatch_ctrl_bcd_digit_inc.sv | 23 ++
 rtl/stopwatch_ctrl.sv | 132 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a; the commands are single-cycle pulses with no handshake.
package stopwatch_ctrl_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit_inc.sv
// Single BCD digit incrementer with a configurable wrap value and carry-out.
// Latency: combinational, zero cycles.
// Backpressure: none; enable qualifies the increment and carry chains to the next digit.
module bcd_digit_inc
    import stopwatch_ctrl_pkg::*;
(
    input  logic [DIGIT_W-1:0] value,
    input  logic               enable,
    input  logic [DIGIT_W-1:0] max,
    output logic [DIGIT_W-1:0] next_val,
    output logic               carry
);

    // Carry fires only when this digit is enabled and sits at its last value.
    always_comb begin
        carry    = enable && (value == max);
        next_val = value;
        if (enable) begin
            next_val = carry ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Two-digit BCD stopwatch: prescaled tick, IDLE/RUN/PAUSE control, optional lap freeze (STOPWATCH_LAP_EN).
// Latency: digits update on the edge after the prescaler terminal cycle; running follows the state on the same edge.
// Backpressure: none; start_stop/clear/lap are sampled every cycle and a held level counts once per cycle.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int ONES_MAX = 9,
    parameter int TENS_MAX = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_stop,
    input  logic               clear,
`ifdef STOPWATCH_LAP_EN
    input  logic               lap,
`endif
    output logic [DIGIT_W-1:0] ones,
    output logic [DIGIT_W-1:0] tens,
    output logic               running,
    output logic               wrap
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t               state;
    state_t               state_nxt;
    logic [PW-1:0]        presc;
    logic                 tick;
    logic [DIGIT_W-1:0]   ones_q;
    logic [DIGIT_W-1:0]   tens_q;
    logic [DIGIT_W-1:0]   ones_nxt;
    logic [DIGIT_W-1:0]   tens_nxt;
    logic                 ones_cy;
    logic                 tens_cy;

    // A tick is the terminal prescaler cycle, and only counts while running.
    assign tick = (state == RUN) && (presc == PRESC_LAST);

    // Next-state: clear beats start_stop; start_stop toggles between RUN and PAUSE.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else if (start_stop) begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = PAUSE;
                PAUSE:   state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register; running is registered from the next state so both move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == RUN);
        end
    end

    // Prescaler advances only in RUN; PAUSE holds it so a resume continues mid-period.
    always_ff @(posedge clk) begin
        if (rst || clear || (state == IDLE)) begin
            presc <= '0;
        end else if (state == RUN) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    bcd_digit_inc u_ones (
        .value    (ones_q),
        .enable   (tick),
        .max      (DIGIT_W'(ONES_MAX)),
        .next_val (ones_nxt),
        .carry    (ones_cy)
    );

    bcd_digit_inc u_tens (
        .value    (tens_q),
        .enable   (ones_cy),
        .max      (DIGIT_W'(TENS_MAX)),
        .next_val (tens_nxt),
        .carry    (tens_cy)
    );

    // Live count and the one-cycle rollover pulse when the tens digit carries out.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ones_q <= '0;
            tens_q <= '0;
            wrap   <= 1'b0;
        end else begin
            ones_q <= ones_nxt;
            tens_q <= tens_nxt;
            wrap   <= tens_cy;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic               frozen;
    logic [DIGIT_W-1:0] lap_ones;
    logic [DIGIT_W-1:0] lap_tens;

    // Lap toggles the display freeze in RUN; the live count underneath keeps going.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            frozen   <= 1'b0;
            lap_ones <= '0;
            lap_tens <= '0;
        end else if (lap && (state == RUN)) begin
            frozen <= ~frozen;
            if (!frozen) begin
                lap_ones <= ones_q;
                lap_tens <= tens_q;
            end
        end
    end

    assign ones = frozen ? lap_ones : ones_q;
    assign tens = frozen ? lap_tens : tens_q;
`else
    assign ones = ones_q;
    assign tens = tens_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, ONES_MAX=9, TENS_MAX=5.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
    logic       lap = 1'b0;
`endif
    logic [3:0] ones;
    logic [3:0] tens;
    logic       running;
    logic       wrap;

    int n_checks = 0;
    int n_fail   = 0;
    logic [9:0] exp;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .TICK_DIV (4),
        .ONES_MAX (9),
        .TENS_MAX (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
`ifdef STOPWATCH_LAP_EN
        .lap        (lap),
`endif
        .ones       (ones),
        .tens       (tens),
        .running    (running),
        .wrap       (wrap)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset wins over a simultaneous start_stop; idle holds with no command.
    task automatic test_reset();
        rst = 1'b1; start_stop = 1'b1;
        step(2);
        start_stop = 1'b0;
        exp = {4'd0, 4'd0, 1'b0, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL reset_state: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        rst = 1'b0;
        step(3);
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL idle_hold: got %h want %h", {tens, ones, running, wrap}, exp);
        end
    endtask

    // Start, then first two increments four cycles apart.
    task automatic test_count();
        start_stop = 1'b1; step(1); start_stop = 1'b0;
        exp = {4'd0, 4'd0, 1'b1, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL start_running: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        step(3);
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL before_first_tick: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        step(1);
        exp = {4'd0, 4'd1, 1'b1, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL first_tick: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        step(4);
        exp = {4'd0, 4'd2, 1'b1, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL second_tick: got %h want %h", {tens, ones, running, wrap}, exp);
        end
    endtask

    // From 02 run to 59, then roll over with a single-cycle wrap pulse.
    task automatic test_wrap();
        step(57 * 4);
        exp = {4'd5, 4'd9, 1'b1, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL reach_59: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        step(3);
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL hold_59: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        step(1);
        exp = {4'd0, 4'd0, 1'b1, 1'b1};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL wrap_pulse: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        step(1);
        exp = {4'd0, 4'd0, 1'b1, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL wrap_one_cycle: got %h want %h", {tens, ones, running, wrap}, exp);
        end
    endtask

    // Pause so the prescaler holds at 2, wait, resume; increment lands two cycles later.
    task automatic test_pause();
        start_stop = 1'b1; step(1); start_stop = 1'b0;
        exp = {4'd0, 4'd0, 1'b0, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL pause_enter: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        step(10);
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL pause_hold: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        start_stop = 1'b1; step(1); start_stop = 1'b0;
        exp = {4'd0, 4'd0, 1'b1, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL resume: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        step(1);
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL resume_plus1: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        step(1);
        exp = {4'd0, 4'd1, 1'b1, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL resume_plus2: got %h want %h", {tens, ones, running, wrap}, exp);
        end
    endtask

    // Run to 37, then clear and start_stop together: clear wins.
    task automatic test_clear_priority();
        step(36 * 4);
        exp = {4'd3, 4'd7, 1'b1, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL reach_37: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        clear = 1'b1; start_stop = 1'b1; step(1); clear = 1'b0; start_stop = 1'b0;
        exp = {4'd0, 4'd0, 1'b0, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL clear_prio: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        step(8);
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL clear_idle_hold: got %h want %h", {tens, ones, running, wrap}, exp);
        end
    endtask

    // Reset mid-count with a tick pending, then restart from 00.
    task automatic test_rst_midcount();
        start_stop = 1'b1; step(1); start_stop = 1'b0;
        step(48);
        exp = {4'd1, 4'd2, 1'b1, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL reach_12: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        step(3);
        rst = 1'b1; step(1); rst = 1'b0;
        exp = {4'd0, 4'd0, 1'b0, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL rst_midcount: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        step(4);
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL no_pending_tick: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        start_stop = 1'b1; step(1); start_stop = 1'b0;
        step(4);
        exp = {4'd0, 4'd1, 1'b1, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL restart_count: got %h want %h", {tens, ones, running, wrap}, exp);
        end
    endtask

    // start_stop on the terminal prescaler cycle: increment applied, then PAUSE.
    task automatic test_tick_coincide();
        step(3);
        start_stop = 1'b1; step(1); start_stop = 1'b0;
        exp = {4'd0, 4'd2, 1'b0, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL tick_and_pause: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        step(8);
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL paused_after_tick: got %h want %h", {tens, ones, running, wrap}, exp);
        end
    endtask

    // Holding start_stop for three cycles toggles three times.
    task automatic test_held_start();
        start_stop = 1'b1;
        step(1);
        n_checks++;
        if (running !== 1'b1) begin
            n_fail++; $display("FAIL held_toggle1: got %b want 1", running);
        end
        step(1);
        n_checks++;
        if (running !== 1'b0) begin
            n_fail++; $display("FAIL held_toggle2: got %b want 0", running);
        end
        step(1);
        start_stop = 1'b0;
        n_checks++;
        if (running !== 1'b1) begin
            n_fail++; $display("FAIL held_toggle3: got %b want 1", running);
        end
        step(2);
        exp = {4'd0, 4'd2, 1'b1, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL held_before_tick: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        step(1);
        exp = {4'd0, 4'd3, 1'b1, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL held_tick: got %h want %h", {tens, ones, running, wrap}, exp);
        end
    endtask

`ifdef STOPWATCH_LAP_EN
    // Freeze display at 05 while the count reaches 08, release, then clear unfreezes.
    task automatic test_lap();
        clear = 1'b1; step(1); clear = 1'b0;
        start_stop = 1'b1; step(1); start_stop = 1'b0;
        step(20);
        lap = 1'b1; step(1); lap = 1'b0;
        exp = {4'd0, 4'd5, 1'b1, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL lap_freeze: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        step(12);
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL lap_hold: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        lap = 1'b1; step(1); lap = 1'b0;
        exp = {4'd0, 4'd8, 1'b1, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL lap_release: got %h want %h", {tens, ones, running, wrap}, exp);
        end
        lap = 1'b1; step(1); lap = 1'b0;
        clear = 1'b1; step(1); clear = 1'b0;
        exp = {4'd0, 4'd0, 1'b0, 1'b0};
        n_checks++;
        if ({tens, ones, running, wrap} !== exp) begin
            n_fail++; $display("FAIL lap_clear: got %h want %h", {tens, ones, running, wrap}, exp);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_pause();
        test_clear_priority();
        test_rst_midcount();
        test_tick_coincide();
        test_held_start();
`ifdef STOPWATCH_LAP_EN
        test_lap();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
